// File: rtl/confreg_axil_pkg.sv
// confreg_axil_pkg: shared types for the confreg AXI4-Lite arbiter.
//   state_t    - sequencer states
//   axi_resp_t - AXI4-Lite BRESP/RRESP encodings
//   req_t      - one requester's latched transaction fields
package confreg_axil_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  // addr is carried at full AXI width; the top uses only its ADDR_W bits.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/confreg_axil_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-port request
//   en       : commit the current grant into last_grant
//   gnt      : index of the granted port (valid when |req)
// last_grant resets to 1 so port 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    if (req == 2'b11) begin
      gnt = ~last_grant_q;
    end else begin
      gnt = req[1];
    end
    last_grant_d = last_grant_q;
    if (en) begin
      last_grant_d = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/confreg_axil_arbiter.sv
// confreg_axil_arbiter: shares the confreg AXI4-Lite slave port between two
// hold-until-done requesters (0 = CPU uncached, 1 = debug). One transaction
// outstanding; every AXI output and the response are registered.
//   ACLK, ARESET            : clock, synchronous active-high reset
//   req/req_we/req_addr/... : per-port request, held until done
//   done, rsp_rdata/resp    : one-cycle completion pulse and its response
//   M_AXI_*                 : AXI4-Lite master (AW/W/B/AR/R)
module confreg_axil_arbiter
  import confreg_axil_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NREQ   = 2
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               req_we,
  input  logic [NREQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NREQ-1:0][31:0]         req_wdata,
  input  logic [NREQ-1:0][3:0]          req_wstrb,
  output logic [NREQ-1:0]               done,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [ADDR_W-1:0]             M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [ADDR_W-1:0]             M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  if (NREQ != 2) begin : g_nreq_check
    $error("confreg_axil_arbiter supports NREQ == 2 only");
  end

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  req_t              hold_q, hold_d;
  req_t              sel;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              arb_gnt;
  logic              arb_en;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic              unused_hold;

  rr_arb2 u_arb (
    .clk (ACLK),
    .rst (ARESET),
    .req (req[1:0]),
    .en  (arb_en),
    .gnt (arb_gnt)
  );

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q  & M_AXI_WREADY;
  assign b_hs  = bready_q  & M_AXI_BVALID;
  assign ar_hs = arvalid_q & M_AXI_ARREADY;
  assign r_hs  = rready_q  & M_AXI_RVALID;

  always_comb begin
    sel.we    = req_we[arb_gnt];
    sel.addr  = 32'(req_addr[arb_gnt]);
    sel.wdata = req_wdata[arb_gnt];
    sel.wstrb = req_wstrb[arb_gnt];
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    hold_d    = hold_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    arb_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          arb_en  = 1'b1;
          grant_d = arb_gnt;
          hold_d  = sel;
          if (sel.we) begin
            state_d   = S_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        // AW and W retire independently; leave once both have, in any order.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d  = S_WRESP;
          bready_d = 1'b1;
        end
      end
      S_WRESP: begin
        if (b_hs) begin
          bready_d        = 1'b0;
          resp_d          = M_AXI_BRESP;
          rdata_d         = '0;
          done_d[grant_q] = 1'b1;
          state_d         = S_DONE;
        end
      end
      S_RADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_hs) begin
          rready_d        = 1'b0;
          resp_d          = M_AXI_RRESP;
          rdata_d         = M_AXI_RDATA;
          done_d[grant_q] = 1'b1;
          state_d         = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      hold_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // we, addr[1:0] and addr bits above ADDR_W are not needed after the grant.
  assign unused_hold = ^{hold_q.we, hold_q.addr};

  assign M_AXI_AWADDR  = {hold_q.addr[ADDR_W-1:2], 2'b00};
  assign M_AXI_ARADDR  = {hold_q.addr[ADDR_W-1:2], 2'b00};
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = hold_q.wdata;
  assign M_AXI_WSTRB   = hold_q.wstrb;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign done          = done_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_confreg_axil_arbiter.sv
// Directed bench for confreg_axil_arbiter with a small AXI4-Lite slave model
// (register array, programmable AWREADY/WREADY delay, SLVERR at 0xFC,
// optional R stall).
module tb_confreg_axil_arbiter;
  import confreg_axil_pkg::*;

  localparam int unsigned ADDR_W = 8;

  logic                      ACLK = 1'b0;
  logic                      ARESET;
  logic [1:0]                req, req_we;
  logic [1:0][ADDR_W-1:0]    req_addr;
  logic [1:0][31:0]          req_wdata;
  logic [1:0][3:0]           req_wstrb;
  logic [1:0]                done;
  logic [31:0]               rsp_rdata;
  logic [1:0]                rsp_resp;
  logic [ADDR_W-1:0]         M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]                M_AXI_AWPROT, M_AXI_ARPROT;
  logic                      M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0]               M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]                M_AXI_WSTRB;
  logic [1:0]                M_AXI_BRESP, M_AXI_RRESP;
  logic                      M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic                      M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  confreg_axil_arbiter #(.ADDR_W(ADDR_W), .NREQ(2)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .done(done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model ----------------
  logic [31:0]       mem [0:63];
  int                aw_delay, w_delay;
  bit                r_stall;
  int                aw_cnt, w_cnt;
  logic              got_aw, got_w, bvalid_r, rvalid_r, r_pend;
  logic [ADDR_W-1:0] aw_addr_l;
  logic [31:0]       w_data_l, rdata_r;
  logic [3:0]        w_strb_l;
  logic [1:0]        rresp_r;
  int                writes_cnt, aw_hs_cnt, w_hs_cnt;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_delay);
  assign M_AXI_ARREADY = M_AXI_ARVALID;
  assign M_AXI_BVALID  = bvalid_r;
  assign M_AXI_BRESP   = 2'b00;
  assign M_AXI_RVALID  = rvalid_r;
  assign M_AXI_RDATA   = rdata_r;
  assign M_AXI_RRESP   = rresp_r;

  always @(posedge ACLK) begin : slave
    logic              naw, nw;
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [3:0]        s;
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0; r_pend <= 1'b0;
      rdata_r <= '0; rresp_r <= 2'b00;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
      naw = got_aw; a = aw_addr_l;
      nw  = got_w;  d = w_data_l; s = w_strb_l;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        naw = 1'b1; a = M_AXI_AWADDR; aw_hs_cnt <= aw_hs_cnt + 1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        nw = 1'b1; d = M_AXI_WDATA; s = M_AXI_WSTRB; w_hs_cnt <= w_hs_cnt + 1;
      end
      if (naw && nw && !bvalid_r) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[a[7:2]][8*b +: 8] <= d[8*b +: 8];
        writes_cnt <= writes_cnt + 1;
        bvalid_r <= 1'b1;
        got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        got_aw <= naw; aw_addr_l <= a;
        got_w <= nw; w_data_l <= d; w_strb_l <= s;
      end
      if (bvalid_r && M_AXI_BREADY) bvalid_r <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        rdata_r <= (M_AXI_ARADDR == 8'hFC) ? 32'hDEAD_BEEF : mem[M_AXI_ARADDR[7:2]];
        rresp_r <= (M_AXI_ARADDR == 8'hFC) ? 2'b10 : 2'b00;
        if (r_stall) r_pend <= 1'b1;
        else rvalid_r <= 1'b1;
      end
      if (rvalid_r && M_AXI_RREADY) rvalid_r <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int done_cnt0, done_cnt1, both_cnt, bready_cyc, awv_cyc, wv_cyc;
  int order_q[$];

  always @(posedge ACLK) begin
    if (!ARESET) begin
      if (done[0]) begin done_cnt0++; order_q.push_back(0); end
      if (done[1]) begin done_cnt1++; order_q.push_back(1); end
      if (done == 2'b11) both_cnt++;
      if (M_AXI_BREADY) bready_cyc++;
      if (M_AXI_AWVALID) awv_cyc++;
      if (M_AXI_WVALID) wv_cyc++;
    end
  end

  // ---------------- helpers ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] rd_log [2];
  logic [1:0]  rs_log [2];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic single(input int p, input logic we, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output int lat, output logic [31:0] rd, output logic [1:0] rs);
    int n;
    bit seen;
    req_we[p] = we; req_addr[p] = addr; req_wdata[p] = wd; req_wstrb[p] = ws;
    req[p] = 1'b1;
    n = 0; seen = 1'b0; lat = -1; rd = 'x; rs = 'x;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (done[p]) begin
        seen = 1'b1; lat = n + 1; rd = rsp_rdata; rs = rsp_resp;
      end
    end
    check("done_seen", 64'(seen), 64'(1));
    tick();
    req[p] = 1'b0;
  endtask

  // Both ports drop req the cycle after their done; with rearm they re-raise
  // one cycle later so contention is continuous.
  task automatic serve(input int target, input bit rearm, output bit ok);
    int n, got;
    bit [1:0] drop, raise;
    got = 0; n = 0; drop = '0; raise = '0;
    while (got < target && n < 400) begin
      tick();
      n++;
      for (int p = 0; p < 2; p++) begin
        if (raise[p]) begin req[p] = 1'b1; raise[p] = 1'b0; end
        if (drop[p]) begin req[p] = 1'b0; drop[p] = 1'b0; if (rearm) raise[p] = 1'b1; end
        if (done[p]) begin drop[p] = 1'b1; got++; rd_log[p] = rsp_rdata; rs_log[p] = rsp_resp; end
      end
    end
    tick();
    req = 2'b00;
    ok = (got == target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] rd;
    logic [1:0] rs;
    bit ok, seen;
    int c0, c1, sb, s_awv, s_wv, s_awhs, s_whs, s_wr, s_br;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    ARESET = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    aw_delay = 0; w_delay = 0; r_stall = 1'b0;
    writes_cnt = 0; aw_hs_cnt = 0; w_hs_cnt = 0;
    repeat (3) tick();

    // reset values
    check("rst_valid_ready", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'(0));
    check("rst_payload", 64'({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB}), 64'(0));
    check("rst_state", 64'(dut.state_q), 64'(S_IDLE));
    ARESET = 1'b0;

    // port 0 write then read
    single(0, 1'b1, 8'h00, 32'h0000_0001, 4'hF, lat, rd, rs);
    check("wr_latency", 64'(lat), 64'(4));
    check("wr_resp", 64'(rs), 64'(0));
    check("wr_rdata_zero", 64'(rd), 64'(0));
    check("wr_done_p0", 64'(done_cnt0), 64'(1));
    check("wr_done_p1", 64'(done_cnt1), 64'(0));
    single(0, 1'b0, 8'h00, 32'h0, 4'h0, lat, rd, rs);
    check("rd_latency", 64'(lat), 64'(4));
    check("rd_data", 64'(rd), 64'(32'h0000_0001));
    check("rd_resp", 64'(rs), 64'(0));
    tick(); tick();
    check("rsp_hold", 64'(rsp_rdata), 64'(32'h0000_0001));

    // simultaneous requests straight after reset: port 0 first
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    order_q.delete();
    req_we = 2'b01;
    req_addr[0] = 8'h04; req_wdata[0] = 32'hA5A5_A5A5; req_wstrb[0] = 4'hF;
    req_addr[1] = 8'h04; req_wdata[1] = 32'h0; req_wstrb[1] = 4'h0;
    req = 2'b11;
    serve(2, 1'b0, ok);
    check("tie_complete", 64'(ok), 64'(1));
    check("tie_count", 64'(order_q.size()), 64'(2));
    check("tie_first", 64'(order_q[0]), 64'(0));
    check("tie_second", 64'(order_q[1]), 64'(1));
    check("tie_p1_rdata", 64'(rd_log[1]), 64'(32'hA5A5_A5A5));
    check("tie_p1_resp", 64'(rs_log[1]), 64'(0));

    // continuous contention: strict alternation
    order_q.delete();
    c0 = done_cnt0; c1 = done_cnt1; sb = both_cnt;
    req_we = 2'b01;
    req_addr[0] = 8'h10; req_wdata[0] = 32'h1111_2222; req_wstrb[0] = 4'hF;
    req_addr[1] = 8'h10;
    req = 2'b11;
    serve(8, 1'b1, ok);
    check("alt_complete", 64'(ok), 64'(1));
    check("alt_count", 64'(order_q.size()), 64'(8));
    for (int i = 0; i < 8; i++) check($sformatf("alt_order%0d", i), 64'(order_q[i]), 64'(i % 2));
    check("alt_no_double_done", 64'(both_cnt - sb), 64'(0));
    check("alt_p0_dones", 64'(done_cnt0 - c0), 64'(4));
    check("alt_p1_dones", 64'(done_cnt1 - c1), 64'(4));

    // AWREADY late, WREADY immediate
    aw_delay = 3; w_delay = 0;
    s_awv = awv_cyc; s_wv = wv_cyc; s_awhs = aw_hs_cnt; s_whs = w_hs_cnt; s_wr = writes_cnt; s_br = bready_cyc;
    single(0, 1'b1, 8'h20, 32'h1234_5678, 4'hF, lat, rd, rs);
    check("awslow_latency", 64'(lat), 64'(7));
    check("awslow_awvalid_cycles", 64'(awv_cyc - s_awv), 64'(4));
    check("awslow_wvalid_cycles", 64'(wv_cyc - s_wv), 64'(1));
    check("awslow_aw_hs", 64'(aw_hs_cnt - s_awhs), 64'(1));
    check("awslow_w_hs", 64'(w_hs_cnt - s_whs), 64'(1));
    check("awslow_writes", 64'(writes_cnt - s_wr), 64'(1));
    check("awslow_bready_cycles", 64'(bready_cyc - s_br), 64'(1));

    // WREADY late, AWREADY immediate
    aw_delay = 0; w_delay = 3;
    s_awv = awv_cyc; s_wv = wv_cyc; s_wr = writes_cnt; s_br = bready_cyc;
    single(1, 1'b1, 8'h24, 32'hCAFE_F00D, 4'hF, lat, rd, rs);
    check("wslow_latency", 64'(lat), 64'(7));
    check("wslow_awvalid_cycles", 64'(awv_cyc - s_awv), 64'(1));
    check("wslow_wvalid_cycles", 64'(wv_cyc - s_wv), 64'(4));
    check("wslow_writes", 64'(writes_cnt - s_wr), 64'(1));
    check("wslow_bready_cycles", 64'(bready_cyc - s_br), 64'(1));
    w_delay = 0;
    single(0, 1'b0, 8'h20, 32'h0, 4'h0, lat, rd, rs);
    check("awslow_readback", 64'(rd), 64'(32'h1234_5678));
    single(0, 1'b0, 8'h24, 32'h0, 4'h0, lat, rd, rs);
    check("wslow_readback", 64'(rd), 64'(32'hCAFE_F00D));

    // SLVERR passthrough
    c0 = done_cnt0; c1 = done_cnt1;
    single(1, 1'b0, 8'hFC, 32'h0, 4'h0, lat, rd, rs);
    check("slverr_resp", 64'(rs), 64'(2'b10));
    check("slverr_rdata", 64'(rd), 64'(32'hDEAD_BEEF));
    check("slverr_idle", 64'(dut.state_q), 64'(S_IDLE));
    check("slverr_p0_quiet", 64'(done_cnt0 - c0), 64'(0));

    // reset while waiting in RDATA
    r_stall = 1'b1;
    c0 = done_cnt0; c1 = done_cnt1;
    req_we[1] = 1'b0; req_addr[1] = 8'h00; req[1] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (M_AXI_RREADY) seen = 1'b1;
    end
    check("stall_reached_rdata", 64'(seen), 64'(1));
    check("stall_rvalid_low", 64'(M_AXI_RVALID), 64'(0));
    ARESET = 1'b1;
    tick();
    check("midrst_valid_ready", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'(0));
    check("midrst_state", 64'(dut.state_q), 64'(S_IDLE));
    check("midrst_done", 64'(done), 64'(0));
    ARESET = 1'b0; req[1] = 1'b0; r_stall = 1'b0;
    tick();
    check("midrst_no_done", 64'((done_cnt0 - c0) + (done_cnt1 - c1)), 64'(0));
    single(0, 1'b0, 8'h00, 32'h0, 4'h0, lat, rd, rs);
    check("postrst_latency", 64'(lat), 64'(4));
    check("postrst_rdata", 64'(rd), 64'(32'h0000_0001));
    check("postrst_resp", 64'(rs), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
